// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Multi-cycle shift-add multiplier for the execute stage. It sits beside the
// ALU and shifter, takes the same two source operands, and returns a
// 2*WIDTH-bit product after WIDTH iterations (one iteration per clock).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (wins over start)
//   start      request a multiply; sampled on the rising edge
//   is_signed  1 = two's-complement operands, 0 = unsigned; captured with start
//   src1       multiplicand; captured with start
//   src2       multiplier; captured with start
//   busy       high while an operation is in progress (RUN)
//   done       one-cycle pulse; product is valid
//   product    2*WIDTH-bit result; held until the next final iteration or reset
//   zero       high when product == 0; registered together with product
//
// Handshake: start is accepted only when busy is low (IDLE or DONE). An
// accepted start at edge k raises busy after edges k..k+WIDTH-1; done is high
// for exactly the one cycle after edge k+WIDTH. A start seen while busy is
// dropped silently and its operands are never captured. Asserting start during
// the done cycle begins the next operation back to back.
// ---------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 zero
);

    // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [WIDTH-1:0]     acc_q,     acc_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [CW-1:0]        cnt_q,     cnt_d;
    logic                 neg_q,     neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 zero_q,    zero_d;

    // Datapath intermediates for one iteration.
    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   shifted;
    logic [2*WIDTH-1:0]   final_val;

    // Operand magnitudes for capture. Negating the most negative value
    // yields 2^(WIDTH-1), which is still correct read as unsigned.
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;
    logic                 accept;

    always_comb begin
        mag1   = (is_signed && src1[WIDTH-1]) ? -src1 : src1;
        mag2   = (is_signed && src2[WIDTH-1]) ? -src2 : src2;
        accept = start && (state_q != S_RUN);
    end

    // One shift-add step on the {acc, mplier} register pair. The add is
    // WIDTH+1 bits wide so the carry drops into the MSB on the shift.
    always_comb begin
        addend    = mplier_q[0] ? {1'b0, mcand_q} : '0;
        sum       = {1'b0, acc_q} + addend;
        shifted   = {sum, mplier_q[WIDTH-1:1]};
        // -0 is still 0, so a negative sign on a zero product is harmless.
        final_val = neg_q ? -shifted : shifted;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        zero_d    = zero_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d  = S_RUN;
                    acc_d    = '0;
                    mplier_d = mag2;
                    mcand_d  = mag1;
                    cnt_d    = '0;
                    neg_d    = is_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                acc_d    = shifted[2*WIDTH-1:WIDTH];
                mplier_d = shifted[WIDTH-1:0];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    product_d = final_val;
                    zero_d    = (final_val == '0);
                    state_d   = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            zero_q    <= zero_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//
// Drives seq_multiplier with directed and random operands. Every accepted
// start pushes the expected {zero, product} and its start edge into queues;
// a monitor on the falling edge pops and compares whenever done is high.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   src1;
    logic [W-1:0]   src2;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           zero;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .src1      (src1),
        .src2      (src2),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .zero      (zero)
    );

    // ---------------- scoreboard ----------------
    logic [2*W:0] exp_q[$];   // {zero, product}
    int           lat_q[$];   // edge index at which start was sampled
    int           n_cmp = 0;
    int           n_mis = 0;
    logic         prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic on sign- or zero-extended operands.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
        longint     sa;
        longint     sb;
        logic [63:0] p;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        p = 64'(sa * sb);
        return {p == 64'd0, p};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [2*W:0] e;
        int           k;
        if (rst !== 1'b1) begin
            chk_bit("busy_and_done", busy & done, 1'b0);
            if (done) begin
                chk_bit("done_pulse", prev_done, 1'b0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    k = lat_q.pop_front();
                    chk("product", product, e[2*W-1:0]);
                    chk_bit("zero", zero, e[2*W]);
                    chk("latency", 64'(cyc - k), 64'(W));
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // now=1 drives start on the current falling edge (used in the done cycle).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input bit now);
        if (!now) @(negedge clk);
        start     = 1'b1;
        src1      = a;
        src2      = b;
        is_signed = s;
        exp_q.push_back(model(a, b, s));
        lat_q.push_back(cyc + 1);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns on the falling edge where done is high; checks busy (and
    // optionally a held product) on every cycle before that.
    task automatic wait_done(input logic [63:0] hold_val, input bit chk_hold);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) return;
            chk_bit("busy_run", busy, 1'b1);
            if (chk_hold) chk("product_hold", product, hold_val);
        end
        n_cmp++;
        n_mis++;
        $display("FAIL done_timeout: got no done expected done within 200 cycles (cycle %0d)", cyc);
    endtask

    task automatic chk_idle_reset(input string tag);
        chk_bit({tag, "_busy"}, busy, 1'b0);
        chk_bit({tag, "_done"}, done, 1'b0);
        chk({tag, "_product"}, product, 64'd0);
        chk_bit({tag, "_zero"}, zero, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] first_p;
        bit             now;

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; src1 = '0; src2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_reset("reset");

        // Directed corners.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0); wait_done(0, 0);
        issue(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 0); wait_done(0, 0);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 0); wait_done(0, 0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 0); wait_done(0, 0);
        issue(32'h1234_5678, 32'h0000_0000, 1'b0, 0); wait_done(0, 0);
        issue(32'h1234_5678, 32'h0000_0000, 1'b1, 0); wait_done(0, 0);
        issue(32'hFFFF_FFFB, 32'h0000_0000, 1'b1, 0); wait_done(0, 0);
        issue(32'h0000_0000, 32'h8000_0000, 1'b1, 0); wait_done(0, 0);

        // start during RUN is ignored; product must be the first operation's.
        issue(32'h0000_1234, 32'h0000_0010, 1'b0, 0);
        repeat (6) @(negedge clk);
        start = 1'b1; src1 = 32'hDEAD_BEEF; src2 = 32'h0BAD_F00D; is_signed = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0, 0);
        @(negedge clk);
        chk_bit("idle_after_done_busy", busy, 1'b0);

        // Back-to-back: start in the done cycle; first product must hold.
        issue(32'h0000_0003, 32'h0000_0005, 1'b0, 0);
        wait_done(0, 0);
        first_p = 64'd15;
        issue(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1);
        wait_done(first_p, 1);

        // Reset mid-RUN at about iteration 10: done must never pulse.
        issue(32'h0000_0077, 32'h0000_0099, 1'b0, 0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_reset("mid_run_reset");
        repeat (40) @(negedge clk);

        // Reset wins over start in the same cycle.
        start = 1'b1; rst = 1'b1; src1 = 32'h5; src2 = 32'h6; is_signed = 1'b0;
        @(posedge clk);
        #1 start = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk_idle_reset("rst_over_start");

        // Random operands, both signedness, occasional back-to-back starts.
        now = 1'b0;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: a = 32'h8000_0000;
                1: b = 32'h0000_0000;
                2: a = 32'hFFFF_FFFF;
                3: b = 32'h7FFF_FFFF;
                default: ;
            endcase
            s = 1'($urandom_range(0, 1));
            issue(a, b, s, now);
            wait_done(0, 0);
            now = ($urandom_range(0, 3) == 0);
            if (!now) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        n_mis++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "watchdog expired");
    end

endmodule
